alu_cmd_pipe: RTL and testbench

ALU_CMD_PIPE -- requirements
Module: alu_cmd_pipe

---
 rtl/alu_cmd_if.sv | 19 +
 rtl/alu_cmd_pipe.sv | 73 +++++++
 tb/tb_alu_cmd_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_if.sv
// alu_cmd_if: command and result handshake bundle for alu_cmd_pipe.
interface alu_cmd_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic [15:0]      op_count;
    modport master(output in_valid, in_op, in_a, in_b, out_ready,
                   input in_ready, out_valid, out_result, out_carry, out_zero, out_illegal, op_count);
    modport slave(input in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_result, out_carry, out_zero, out_illegal, op_count);
endinterface

// File: rtl/alu_cmd_pipe.sv
// alu_cmd_pipe: input stage register feeding a 2-entry result FIFO, with the ALU between them.
module alu_cmd_pipe #(parameter int WIDTH = 8) (
    input logic   clk,
    input logic   rst,
    alu_cmd_if.slave bus
);
    logic             stg_v;
    logic [2:0]       s_op;
    logic [WIDTH-1:0] s_a, s_b, res;
    logic [WIDTH:0]   sum, dif;
    logic             cry, ill;
    logic [WIDTH+2:0] mem [2];
    logic             wp, rp, rdy;
    logic [1:0]       fcnt, cnt, cnt_n;
    logic [15:0]      ops;
    logic             acc, dlv;

    assign acc = bus.in_valid && rdy;
    assign dlv = bus.out_valid && bus.out_ready;
    assign sum = {1'b0, s_a} + {1'b0, s_b};
    assign dif = {1'b0, s_a} - {1'b0, s_b};
    assign cnt_n = cnt + 2'(acc) - 2'(dlv);

    always_comb begin
        ill = s_op > 3'd4;
        res = s_op == 3'd0 ? sum[WIDTH-1:0] :
              s_op == 3'd1 ? dif[WIDTH-1:0] :
              s_op == 3'd2 ? s_a & s_b :
              s_op == 3'd3 ? s_a | s_b :
              s_op == 3'd4 ? s_a ^ s_b : '0;
        cry = s_op == 3'd0 ? sum[WIDTH] : s_op == 3'd1 ? dif[WIDTH] : 1'b0;
    end

    // The in-flight cap of 2 guarantees the FIFO has room whenever the stage is full,
    // so the stage drains into the FIFO unconditionally every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_v  <= 1'b0;
            s_op   <= '0;
            s_a    <= '0;
            s_b    <= '0;
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            fcnt   <= '0;
            cnt    <= '0;
            rdy    <= 1'b0;
            ops    <= '0;
        end else begin
            stg_v <= acc;
            if (acc) begin
                s_op <= bus.in_op;
                s_a  <= bus.in_a;
                s_b  <= bus.in_b;
            end
            if (stg_v) begin
                mem[wp] <= {ill, res == '0, cry, res};
                wp      <= ~wp;
            end
            if (dlv) rp <= ~rp;
            if (dlv && ops != 16'hFFFF) ops <= ops + 16'd1;
            fcnt <= fcnt + 2'(stg_v) - 2'(dlv);
            cnt  <= cnt_n;
            rdy  <= cnt_n < 2'd2;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = fcnt != 2'd0;
    assign {bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result} = mem[rp];
    assign bus.op_count  = ops;
endmodule

// File: tb/tb_alu_cmd_pipe.sv
// tb_alu_cmd_pipe: directed scenarios plus a random stream against a reference model.
module tb_alu_cmd_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   exp_cnt = 0;

    alu_cmd_if #(.WIDTH(8)) bus();
    alu_cmd_pipe #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result tuple as {illegal, zero, carry, result}.
    function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = {a < b, 8'(a - b)};
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            default: r = 9'd0;
        endcase
        return {op > 3'd4, r[7:0] == 8'd0, r};
    endfunction

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) begin
            total++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) $display("FAIL reset_handshake got %b required 00", {bus.out_valid, bus.in_ready});
        else passed++;
        total++;
        if ({bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result, bus.op_count} !== 27'd0)
            $display("FAIL reset_fields got %h required 0", {bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result, bus.op_count});
        else passed++;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", bus.in_ready);
        else passed++;
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        send(3'd0, 8'hF0, 8'h20);
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL add_latency_early out_valid=%b required 0", bus.out_valid);
        else passed++;
        tick();
        total++;
        if ({bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result} !== {1'b1, 11'b001_0001_0000})
            $display("FAIL add_carry got %h required %h", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result}, {1'b1, 11'b001_0001_0000});
        else passed++;
        tick();
        exp_cnt++;
        total++;
        if ({bus.out_valid, bus.op_count} !== {1'b0, 16'(exp_cnt)}) $display("FAIL add_deliver got %h required %h", {bus.out_valid, bus.op_count}, {1'b0, 16'(exp_cnt)});
        else passed++;
    endtask

    task automatic test_sub();
        send(3'd1, 8'h05, 8'h07);
        tick();
        total++;
        if ({bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result} !== {1'b1, 11'b001_1111_1110})
            $display("FAIL sub_borrow got %h required %h", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result}, {1'b1, 11'b001_1111_1110});
        else passed++;
        tick();
        send(3'd1, 8'h33, 8'h33);
        tick();
        total++;
        if ({bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result} !== {1'b1, 11'b010_0000_0000})
            $display("FAIL sub_zero got %h required %h", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result}, {1'b1, 11'b010_0000_0000});
        else passed++;
        tick();
        exp_cnt += 2;
        total++;
        if (bus.op_count !== 16'(exp_cnt)) $display("FAIL sub_count got %0d required %0d", bus.op_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        {bus.in_op, bus.in_a, bus.in_b} = {3'd2, 8'hF0, 8'h3C};
        tick();
        {bus.in_op, bus.in_a, bus.in_b} = {3'd3, 8'h0F, 8'hF0};
        tick();
        total++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_full in_ready=%b required 0", bus.in_ready);
        else passed++;
        {bus.in_op, bus.in_a, bus.in_b} = {3'd4, 8'hFF, 8'hFF};
        tick();
        tick();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_result} !== {2'b01, 8'h30}) $display("FAIL bp_hold got %h required %h", {bus.in_ready, bus.out_valid, bus.out_result}, {2'b01, 8'h30});
        else passed++;
        bus.out_ready = 1'b1;
        tick();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_result} !== {2'b11, 8'hFF}) $display("FAIL bp_second got %h required %h", {bus.in_ready, bus.out_valid, bus.out_result}, {2'b11, 8'hFF});
        else passed++;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++;
        if ({bus.out_valid, bus.out_zero, bus.out_result} !== {2'b11, 8'h00}) $display("FAIL bp_third got %h required %h", {bus.out_valid, bus.out_zero, bus.out_result}, {2'b11, 8'h00});
        else passed++;
        tick();
        exp_cnt += 3;
        total++;
        if ({bus.out_valid, bus.op_count} !== {1'b0, 16'(exp_cnt)}) $display("FAIL bp_count got %h required %h", {bus.out_valid, bus.op_count}, {1'b0, 16'(exp_cnt)});
        else passed++;
    endtask

    task automatic test_illegal();
        send(3'd6, 8'hAA, 8'h55);
        tick();
        total++;
        if ({bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result} !== {1'b1, 11'b110_0000_0000})
            $display("FAIL illegal got %h required %h", {bus.out_valid, bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result}, {1'b1, 11'b110_0000_0000});
        else passed++;
        tick();
        exp_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic stale = 1'b0;
        bus.out_ready = 1'b0;
        send(3'd0, 8'h01, 8'h02);
        send(3'd0, 8'h03, 8'h04);
        tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.out_valid, bus.in_ready, bus.op_count} !== 18'd0) $display("FAIL midreset_clear got %h required 0", {bus.out_valid, bus.in_ready, bus.op_count});
        else passed++;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        total++;
        if ({stale, bus.op_count} !== 17'd0) $display("FAIL midreset_stale got %h required 0", {stale, bus.op_count});
        else passed++;
    endtask

    task automatic test_stream();
        logic [10:0] q[$];
        logic [10:0] exp;
        int sent = 0, got = 0, cyc = 0, bad = 0;
        logic acc, dlv;
        bus.out_ready = 1'b1;
        bus.in_op = 3'($urandom_range(0, 7));
        bus.in_a = 8'($urandom);
        bus.in_b = 8'($urandom);
        while (got < 100 && cyc < 1000) begin
            bus.in_valid = sent < 100;
            acc = bus.in_valid && bus.in_ready;
            dlv = bus.out_valid;
            if (dlv) begin
                exp = q.size() > 0 ? q[0] : 11'h7FF;
                total++;
                if ({bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result} !== exp) begin
                    bad++;
                    $display("FAIL stream_result #%0d got %h required %h", got, {bus.out_illegal, bus.out_zero, bus.out_carry, bus.out_result}, exp);
                end else passed++;
            end
            if (acc) q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
            tick();
            cyc++;
            if (dlv) begin
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
            if (acc) begin
                sent++;
                bus.in_op = 3'($urandom_range(0, 7));
                bus.in_a = 8'($urandom);
                bus.in_b = 8'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if ({got, 32'(bus.op_count)} !== {32'd100, 32'd100}) $display("FAIL stream_count got %0d/%0d required 100/100", got, bus.op_count);
        else passed++;
        total++;
        if (cyc > 200) $display("FAIL stream_rate cycles=%0d required <=200", cyc);
        else passed++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
